// File: rtl/wimax_pkg.sv
// Shared definitions for the 802.16 OFDM bit interleaver.
// Modulation codes, block geometry lookups and bank/read states.
package wimax_pkg;

  localparam logic [1:0] MOD_BPSK  = 2'd0;
  localparam logic [1:0] MOD_QPSK  = 2'd1;
  localparam logic [1:0] MOD_16QAM = 2'd2;
  localparam logic [1:0] MOD_64QAM = 2'd3;

  localparam int NSUB      = 192;
  localparam int NCBPS_MAX = NSUB * 6;
  localparam int AW        = 11;

  typedef enum logic [1:0] {
    B_EMPTY,
    B_FILLING,
    B_FULL,
    B_DRAINING
  } bank_st_e;

  typedef enum logic {
    RD_IDLE,
    RD_RUN
  } rd_st_e;

  function automatic logic [AW-1:0] ncbps_f(input logic [1:0] m);
    case (m)
      MOD_BPSK:  ncbps_f = AW'(NSUB);
      MOD_QPSK:  ncbps_f = AW'(NSUB * 2);
      MOD_16QAM: ncbps_f = AW'(NSUB * 4);
      default:   ncbps_f = AW'(NSUB * 6);
    endcase
  endfunction

  function automatic logic [6:0] d_f(input logic [1:0] m);
    case (m)
      MOD_BPSK:  d_f = 7'd16;
      MOD_QPSK:  d_f = 7'd32;
      MOD_16QAM: d_f = 7'd64;
      default:   d_f = 7'd96;
    endcase
  endfunction

  function automatic logic [1:0] s_f(input logic [1:0] m);
    case (m)
      MOD_16QAM: s_f = 2'd2;
      MOD_64QAM: s_f = 2'd3;
      default:   s_f = 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/ofdm_intlv_addr.sv
// Write-side address generator: walks k and yields the
// interleaved write index jk using only counters and adds.
module ofdm_intlv_addr
  import wimax_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [1:0]    mod_sel,
  output logic [AW-1:0] jk,
  output logic          last_k,
  output logic [1:0]    mode
);

  logic [3:0]    c12_q, c12_d;
  logic [1:0]    c3_q, c3_d;
  logic [6:0]    q_q, q_d;
  logic [1:0]    q3_q, q3_d;
  logic [AW-1:0] mk_q, mk_d;
  logic [1:0]    mode_q, mode_d;
  logic          first;
  logic [6:0]    d;
  logic [2:0]    diff;
  logic [1:0]    rot;

  always_comb begin
    first  = (c12_q == 4'd0) && (q_q == 7'd0);
    mode   = first ? mod_sel : mode_q;
    d      = d_f(mode);
    last_k = (c12_q == 4'd11) && (q_q == d - 7'd1);
    // with d a multiple of 3, mk mod 3 equals q mod 3
    diff   = 3'd3 + {1'b0, q3_q} - {1'b0, c3_q};
    rot    = (diff >= 3'd3) ? 2'(diff - 3'd3) : diff[1:0];
    case (s_f(mode))
      2'd2:    jk = {mk_q[AW-1:1], mk_q[0] ^ c12_q[0]};
      2'd3:    jk = mk_q - AW'(q3_q) + AW'(rot);
      default: jk = mk_q;
    endcase
  end

  always_comb begin
    c12_d  = c12_q;
    c3_d   = c3_q;
    q_d    = q_q;
    q3_d   = q3_q;
    mk_d   = mk_q;
    mode_d = mode_q;
    if (en) begin
      mode_d = mode;
      if (last_k) begin
        c12_d = '0;
        c3_d  = '0;
        q_d   = '0;
        q3_d  = '0;
        mk_d  = '0;
      end else if (c12_q == 4'd11) begin
        c12_d = '0;
        c3_d  = '0;
        q_d   = q_q + 7'd1;
        q3_d  = (q3_q == 2'd2) ? 2'd0 : q3_q + 2'd1;
        mk_d  = AW'(q_q) + AW'(1);
      end else begin
        c12_d = c12_q + 4'd1;
        c3_d  = (c3_q == 2'd2) ? 2'd0 : c3_q + 2'd1;
        mk_d  = mk_q + AW'(d);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c12_q  <= '0;
      c3_q   <= '0;
      q_q    <= '0;
      q3_q   <= '0;
      mk_q   <= '0;
      mode_q <= '0;
    end else begin
      c12_q  <= c12_d;
      c3_q   <= c3_d;
      q_q    <= q_d;
      q3_q   <= q3_d;
      mk_q   <= mk_d;
      mode_q <= mode_d;
    end
  end

endmodule

// File: rtl/ofdm_intlv.sv
// 802.16 OFDM bit interleaver with ping-pong banks:
// one bank fills in permuted order while the other drains.
module ofdm_intlv
  import wimax_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mod_sel,
  input  logic       in_bits,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_bits,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last
);

  logic          mem_q [2][NCBPS_MAX];
  bank_st_e      st_q [2];
  bank_st_e      st_d [2];
  logic [1:0]    bmode_q [2];
  logic [1:0]    bmode_d [2];
  logic          wbank_q, wbank_d;
  logic          rbank_q, rbank_d;
  rd_st_e        rs_q, rs_d;
  logic [AW-1:0] r_q, r_d;
  logic          ob_q, ob_d;
  logic          ov_q, ov_d;
  logic          ol_q, ol_d;

  logic          wr_fire;
  logic [AW-1:0] jk;
  logic          last_k;
  logic [1:0]    wmode;
  logic          nrb;
  logic          ld;
  logic [AW-1:0] n_cur;

  assign in_ready = (st_q[wbank_q] == B_EMPTY) ||
                    (st_q[wbank_q] == B_FILLING);
  assign wr_fire  = in_valid && in_ready;
  assign out_bits  = ob_q;
  assign out_valid = ov_q;
  assign out_last  = ol_q;

  ofdm_intlv_addr u_addr (
    .clk     (clk),
    .reset   (reset),
    .en      (wr_fire),
    .mod_sel (mod_sel),
    .jk      (jk),
    .last_k  (last_k),
    .mode    (wmode)
  );

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wbank_q][jk] <= in_bits;
  end

  always_comb begin
    st_d    = st_q;
    bmode_d = bmode_q;
    wbank_d = wbank_q;
    rbank_d = rbank_q;
    rs_d    = rs_q;
    r_d     = r_q;
    ob_d    = ob_q;
    ov_d    = ov_q;
    ol_d    = ol_q;
    nrb     = ~rbank_q;
    ld      = !ov_q || out_ready;
    n_cur   = ncbps_f(bmode_q[rbank_q]);

    if (wr_fire) begin
      st_d[wbank_q] = last_k ? B_FULL : B_FILLING;
      if (last_k) begin
        bmode_d[wbank_q] = wmode;
        wbank_d          = ~wbank_q;
      end
    end

    // read and write never touch the same bank in one cycle
    unique case (rs_q)
      RD_IDLE: begin
        if (st_q[rbank_q] == B_FULL) begin
          rs_d          = RD_RUN;
          st_d[rbank_q] = B_DRAINING;
          r_d           = '0;
        end
      end
      RD_RUN: begin
        if (ov_q && out_ready && ol_q) begin
          st_d[rbank_q] = B_EMPTY;
          rbank_d       = nrb;
          if (st_q[nrb] == B_FULL) begin
            st_d[nrb] = B_DRAINING;
            ob_d      = mem_q[nrb][0];
            ov_d      = 1'b1;
            ol_d      = 1'b0;
            r_d       = AW'(1);
          end else begin
            rs_d = RD_IDLE;
            ob_d = 1'b0;
            ov_d = 1'b0;
            ol_d = 1'b0;
          end
        end else if (ld) begin
          ob_d = mem_q[rbank_q][r_q];
          ov_d = 1'b1;
          ol_d = (r_q == n_cur - AW'(1));
          r_d  = r_q + AW'(1);
        end
      end
      default: rs_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q[0]    <= B_EMPTY;
      st_q[1]    <= B_EMPTY;
      bmode_q[0] <= '0;
      bmode_q[1] <= '0;
      wbank_q    <= 1'b0;
      rbank_q    <= 1'b0;
      rs_q       <= RD_IDLE;
      r_q        <= '0;
      ob_q       <= 1'b0;
      ov_q       <= 1'b0;
      ol_q       <= 1'b0;
    end else begin
      st_q    <= st_d;
      bmode_q <= bmode_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      rs_q    <= rs_d;
      r_q     <= r_d;
      ob_q    <= ob_d;
      ov_q    <= ov_d;
      ol_q    <= ol_d;
    end
  end

endmodule

// File: tb/tb_ofdm_intlv.sv
// Scoreboard bench for ofdm_intlv: random and directed blocks
// checked against a textbook 802.16 two-step permutation model.
module tb_ofdm_intlv;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mod_sel;
  logic       in_bits;
  logic       in_valid;
  logic       in_ready;
  logic       out_bits;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  ofdm_intlv dut (
    .clk       (clk),
    .reset     (reset),
    .mod_sel   (mod_sel),
    .in_bits   (in_bits),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_bits  (out_bits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit b;
    bit l;
  } exp_t;

  exp_t exp_q[$];
  int   ones_k[$];
  bit   blk_in[1152];
  bit   cur_blk[1152];
  bit   last_blk[1152];
  int   last_len = 0;
  int   pos = 0;
  int   blocks_done = 0;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_last_cyc = 0;
  int   last_gap = -1;
  bit   prev_last = 0;
  bit   rnd_rdy = 0;
  bit   rnd_in = 0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  function automatic int ncbps_m(input int m);
    return 192 * ((m == 0) ? 1 : (m == 1) ? 2 : (m == 2) ? 4 : 6);
  endfunction

  // out[jk] = in[k], with the standard first and second permutations
  function automatic void model_push(input int m);
    int n, d, s, mk, jk;
    bit o[1152];
    n = ncbps_m(m);
    d = n / 12;
    s = (m == 2) ? 2 : (m == 3) ? 3 : 1;
    for (int k = 0; k < n; k++) begin
      mk = d * (k % 12) + k / 12;
      jk = s * (mk / s) + (mk + n - (12 * mk) / n) % s;
      o[jk] = blk_in[k];
    end
    for (int j = 0; j < n; j++) exp_q.push_back('{o[j], j == n - 1});
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      exp_t e;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_empty: got bit %0d with nothing expected", out_bits);
      end else begin
        e = exp_q.pop_front();
        if (out_bits !== e.b || out_last !== e.l) begin
          fails++;
          $display("FAIL sb_bit pos %0d: got b=%0d l=%0d expected b=%0d l=%0d",
                   pos, out_bits, out_last, e.b, e.l);
        end
      end
      cur_blk[pos] = out_bits;
      if (prev_last) last_gap = cyc - last_last_cyc;
      prev_last = 0;
      if (out_last) begin
        for (int i = 0; i < 1152; i++) last_blk[i] = (i <= pos) ? cur_blk[i] : 1'b0;
        last_len = pos + 1;
        blocks_done++;
        pos = 0;
        prev_last = 1;
        last_last_cyc = cyc;
      end else if (pos < 1151) begin
        pos++;
      end
    end
  end

  task automatic send_block(input int m, input int kind, input int nstop);
    int n, lim, w;
    n = ncbps_m(m);
    for (int k = 0; k < n; k++) begin
      if (kind != 0) blk_in[k] = 1'($urandom_range(0, 1));
      else begin
        blk_in[k] = 1'b0;
        foreach (ones_k[i]) if (ones_k[i] == k) blk_in[k] = 1'b1;
      end
    end
    if (nstop >= n) model_push(m);
    lim = (nstop < n) ? nstop : n;
    for (int k = 0; k < lim; k++) begin
      if (rnd_in && $urandom_range(0, 7) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      in_bits  = blk_in[k];
      mod_sel  = (k == 0) ? 2'(m) : 2'($urandom_range(0, 3));
      in_valid = 1'b1;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 3000) begin
        w++;
        @(negedge clk);
      end
      if (!in_ready) begin
        chk("in_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_blocks(input int target);
    int w;
    w = 0;
    while (blocks_done < target && w < 5000) begin
      @(posedge clk);
      w++;
    end
    #1;
    chk("blk_wait", int'(blocks_done >= target), 1);
  endtask

  function automatic int ones_cnt();
    int c;
    c = 0;
    for (int i = 0; i < 1152; i++) c += int'(last_blk[i]);
    return c;
  endfunction

  initial begin
    int bd;
    int w;
    reset = 1'b0;
    in_valid = 1'b0;
    in_bits = 1'b0;
    mod_sel = 2'd0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_bits", int'(out_bits), 0);
    chk("rst_out_last", int'(out_last), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);

    ones_k = '{1};
    send_block(0, 0, 9999);
    @(posedge clk);
    #1;
    chk("lat_cyc1", int'(out_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_cyc2", int'(out_valid), 1);
    wait_blocks(1);
    chk("bpsk_len", last_len, 192);
    chk("bpsk_pos16", int'(last_blk[16]), 1);
    chk("bpsk_ones", ones_cnt(), 1);

    ones_k = '{0, 1, 12};
    send_block(2, 0, 9999);
    wait_blocks(2);
    chk("qam16_len", last_len, 768);
    chk("qam16_pos0", int'(last_blk[0]), 1);
    chk("qam16_pos1", int'(last_blk[1]), 1);
    chk("qam16_pos65", int'(last_blk[65]), 1);
    chk("qam16_ones", ones_cnt(), 3);

    ones_k = '{1};
    send_block(3, 0, 9999);
    wait_blocks(3);
    chk("qam64_len", last_len, 1152);
    chk("qam64_pos98", int'(last_blk[98]), 1);
    chk("qam64_ones", ones_cnt(), 1);

    send_block(3, 1, 9999);
    wait_blocks(4);

    send_block(1, 1, 9999);
    send_block(0, 1, 9999);
    wait_blocks(6);
    chk("b2b_gap", last_gap, 1);
    chk("b2b_len", last_len, 192);

    out_ready = 1'b0;
    send_block(2, 1, 9999);
    send_block(1, 1, 9999);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_in_ready", int'(in_ready), 0);
    chk("hold_valid", int'(out_valid), 1);
    chk("hold_bit", int'(out_bits), int'(exp_q[0].b));
    chk("hold_last", int'(out_last), 0);
    repeat (20) @(posedge clk);
    #1;
    chk("hold_valid2", int'(out_valid), 1);
    chk("hold_bit2", int'(out_bits), int'(exp_q[0].b));
    chk("hold_in_ready2", int'(in_ready), 0);
    fork
      send_block(0, 1, 9999);
      begin
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_blocks(9);

    send_block(2, 1, 9999);
    send_block(0, 1, 101);
    reset = 1'b0;
    exp_q.delete();
    pos = 0;
    prev_last = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_valid", int'(out_valid), 0);
    chk("post_rst_in_ready", int'(in_ready), 1);
    bd = blocks_done;
    ones_k = '{1};
    send_block(3, 0, 9999);
    wait_blocks(bd + 1);
    chk("post_rst_pos98", int'(last_blk[98]), 1);
    chk("post_rst_ones", ones_cnt(), 1);

    rnd_rdy = 1;
    rnd_in = 1;
    repeat (6) send_block($urandom_range(0, 3), 1, 9999);
    rnd_in = 0;
    w = 0;
    while (exp_q.size() != 0 && w < 20000) begin
      @(posedge clk);
      w++;
    end
    rnd_rdy = 0;
    #2;
    out_ready = 1'b1;
    chk("drain_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
